// File: rtl/div_pkg.sv
// div_pkg: constants and types shared by the divider dispatcher and its FIFO.
//   DIV_WIDTH : default operand/result width
//   DIV_TAG_W : default caller tag width
//   DIV_DEPTH : default request FIFO depth
//   div_state_e : dispatcher state (IDLE = no divide outstanding,
//                 WAIT = one divide issued, waiting for its result)
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_TAG_W = 4;
  localparam int DIV_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: synchronous FIFO holding pending divide requests.
// Ports:
//   clk_in      : clock
//   rst_n_in    : asynchronous active-low reset, empties the FIFO
//   push        : write push_data (ignored while full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored while empty)
//   pop_data    : current head entry (valid while !empty)
//   full, empty : occupancy flags
module div_req_fifo #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              push_en;
  logic              pop_en;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_en && !pop_en) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop_en && !push_en) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/div_dispatcher.sv
// div_dispatcher: queues tagged divide requests and feeds them one at a time
// to a multi-cycle divider, returning each result with its tag in order.
// Ports:
//   clk_in, rst_n_in         : clock, asynchronous active-low reset
//   s_*                      : request side (dividend, divisor, tag, valid/ready)
//   div_dividend_out/divisor : operands to the divider, div_valid_out start pulse
//   div_quotient/remainder/error_in, div_valid_in : divider result pulse
//   div_busy_in              : divider cannot accept a start
//   m_*                      : result side (quotient, remainder, tag, error,
//                              valid/ready)
module div_dispatcher
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int DEPTH = DIV_DEPTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] s_dividend_in,
  input  logic [WIDTH-1:0] s_divisor_in,
  input  logic [TAG_W-1:0] s_tag_in,
  input  logic             s_valid_in,
  output logic             s_ready_out,
  output logic [WIDTH-1:0] div_dividend_out,
  output logic [WIDTH-1:0] div_divisor_out,
  output logic             div_valid_out,
  input  logic [WIDTH-1:0] div_quotient_in,
  input  logic [WIDTH-1:0] div_remainder_in,
  input  logic             div_error_in,
  input  logic             div_valid_in,
  input  logic             div_busy_in,
  output logic [WIDTH-1:0] m_quotient_out,
  output logic [WIDTH-1:0] m_remainder_out,
  output logic [TAG_W-1:0] m_tag_out,
  output logic             m_error_out,
  output logic             m_valid_out,
  input  logic             m_ready_in
);

  localparam int ENTRY_W = 2 * WIDTH + TAG_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [WIDTH-1:0]   head_dividend;
  logic [WIDTH-1:0]   head_divisor;
  logic [TAG_W-1:0]   head_tag;

  div_state_e         state_reg;
  div_state_e         state_next;
  logic               issue;
  logic               capture;

  logic               div_valid_reg;
  logic [WIDTH-1:0]   div_dividend_reg;
  logic [WIDTH-1:0]   div_divisor_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               m_valid_reg;
  logic               m_error_reg;
  logic [WIDTH-1:0]   m_quotient_reg;
  logic [WIDTH-1:0]   m_remainder_reg;
  logic [TAG_W-1:0]   m_tag_reg;

  div_req_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_req_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (s_valid_in),
    .push_data ({s_dividend_in, s_divisor_in, s_tag_in}),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_dividend = head[ENTRY_W-1 -: WIDTH];
  assign head_divisor  = head[TAG_W +: WIDTH];
  assign head_tag      = head[TAG_W-1:0];

  // Ready depends on occupancy only, never on s_valid_in.
  assign s_ready_out = !fifo_full;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A new divide starts only when the output register is free, so a result
  // can never arrive while the previous one is still waiting for the consumer.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !m_valid_reg && !div_busy_in) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (div_valid_in) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // div_valid_in outside WAIT is a leftover from a divide abandoned by reset
  // and is dropped because capture is only raised in WAIT.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_valid_reg    <= 1'b0;
      div_dividend_reg <= '0;
      div_divisor_reg  <= '0;
      tag_reg          <= '0;
      m_valid_reg      <= 1'b0;
      m_error_reg      <= 1'b0;
      m_quotient_reg   <= '0;
      m_remainder_reg  <= '0;
      m_tag_reg        <= '0;
    end else begin
      div_valid_reg <= issue;
      if (issue) begin
        div_dividend_reg <= head_dividend;
        div_divisor_reg  <= head_divisor;
        tag_reg          <= head_tag;
      end
      if (capture) begin
        m_valid_reg     <= 1'b1;
        m_error_reg     <= div_error_in;
        m_quotient_reg  <= div_quotient_in;
        m_remainder_reg <= div_remainder_in;
        m_tag_reg       <= tag_reg;
      end else if (m_valid_reg && m_ready_in) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign div_valid_out    = div_valid_reg;
  assign div_dividend_out = div_dividend_reg;
  assign div_divisor_out  = div_divisor_reg;
  assign m_valid_out      = m_valid_reg;
  assign m_error_out      = m_error_reg;
  assign m_quotient_out   = m_quotient_reg;
  assign m_remainder_out  = m_remainder_reg;
  assign m_tag_out        = m_tag_reg;

endmodule

// File: doc/div_dispatcher.md
DIV_DISPATCHER -- requirements
Module: div_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 32: dividend, divisor, quotient and remainder width, matching the divider.
REQ-002 SHALL have parameter DEPTH, default 4: request FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter TAG_W, default 4: width of the caller tag carried from request to result.
REQ-004 SHALL have ports:
- clk_in  in  1  sole clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- s_dividend_in  in  WIDTH  request dividend.
- s_divisor_in  in  WIDTH  request divisor.
- s_tag_in  in  TAG_W  request tag.
- s_valid_in  in  1  request valid.
- s_ready_out  out  1  request accepted when high with s_valid_in.
- div_dividend_out  out  WIDTH  operand to divider.
- div_divisor_out  out  WIDTH  operand to divider.
- div_valid_out  out  1  one-cycle start pulse to divider.
- div_quotient_in  in  WIDTH  divider quotient.
- div_remainder_in  in  WIDTH  divider remainder.
- div_error_in  in  1  divide-by-zero flag.
- div_valid_in  in  1  one-cycle result pulse from divider.
- div_busy_in  in  1  divider busy.
- m_quotient_out  out  WIDTH  result quotient.
- m_remainder_out  out  WIDTH  result remainder.
- m_tag_out  out  TAG_W  tag of the request that produced the result.
- m_error_out  out  1  divide-by-zero result.
- m_valid_out  out  1  result valid.
- m_ready_in  in  1  consumer accepts result.

Function
REQ-005 SHALL accept a request on every rising edge where s_valid_in and s_ready_out are both high, pushing {dividend, divisor, tag} into the FIFO.
REQ-006 SHALL drive s_ready_out = FIFO not full, registered or combinational from occupancy only, never from s_valid_in.
REQ-007 SHALL implement a state machine with states IDLE and WAIT.
- IDLE -> WAIT: FIFO non-empty, m_valid_out low, div_busy_in low.
- That cycle: pop the head entry, register its operands onto div_dividend_out/div_divisor_out, and pulse div_valid_out for exactly one cycle.
REQ-008 SHALL, in WAIT, hold the issued tag; on div_valid_in, capture quotient, remainder, error and tag into the output register, set m_valid_out next edge, and return to IDLE.
REQ-009 SHALL keep at most one request outstanding at the divider; div_valid_out SHALL never pulse in WAIT.
REQ-010 SHALL hold m_* outputs stable while m_valid_out is high and m_ready_in is low; m_valid_out clears on the edge where m_ready_in is high.
REQ-011 SHALL ignore div_valid_in in IDLE (stale result after local reset).
REQ-012 SHALL support divide-by-zero returning one cycle after issue and normal divides returning 33 cycles after issue; no timeout.
REQ-013 SHALL permit a simultaneous push and pop on a non-full FIFO without loss; a push while full is refused by s_ready_out low.
REQ-014 SHALL return results in request order.
REQ-015 SHALL keep FIFO pointers wrapping modulo DEPTH, with occupancy counter range 0..DEPTH.

Reset
REQ-016 SHALL, on rst_n_in low, asynchronously clear state to IDLE, empty the FIFO, and drive div_valid_out=0, m_valid_out=0, m_error_out=0, and all data/tag outputs to 0; s_ready_out SHALL be 1 after reset release.
REQ-017 SHALL discard any in-flight request on reset mid-operation; no result for it is presented.

Structure
REQ-018 SHALL place the state enum (IDLE, WAIT) and default WIDTH/TAG_W constants in shared package div_pkg.
REQ-019 SHALL implement buffering as sub-module div_req_fifo, a synchronous FIFO with push/pop/full/empty and the same asynchronous reset.

Verification
REQ-020 Single request 100/7, tag 3 -> div_valid_out pulses once with 100/7; after divider return, m_quotient_out=14, m_remainder_out=2, m_tag_out=3, m_error_out=0.
REQ-021 Request 5/0, tag 9 -> result valid two cycles after issue, m_error_out=1, quotient=0, remainder=0, tag=9.
REQ-022 Five back-to-back requests with DEPTH=4 while the divider is busy -> s_ready_out low after the fourth FIFO entry; all five results in order with correct tags.
REQ-023 Consumer holds m_ready_in=0 for 50 cycles with results pending -> m_* stable, no new div_valid_out pulse; it resumes the cycle after acceptance.
REQ-024 Assert rst_n_in mid-divide with 2 queued -> all outputs 0 immediately; stale div_valid_in ignored; no m_valid_out until new requests arrive.
